// File: rtl/vs0_dma_pkg.sv
// vs0_dma_pkg: register offsets, CTRL/STATUS bit positions and master FSM states
// shared by the vs0_dma copy engine.
package vs0_dma_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_SRC      = 3'd2;
  localparam logic [2:0] OFF_DST      = 3'd3;
  localparam logic [2:0] OFF_LEN      = 3'd4;
  localparam logic [2:0] OFF_IRQ_MASK = 3'd5;
  localparam logic [2:0] OFF_REMAIN   = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_ABORT = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/vs0_dma_regs.sv
// vs0_dma_regs: slave-port decode, registered ack, register file, W1C status and
// START/ABORT pulses. IRQ_MASK exists only when VS0_DMA_IRQ_FWD_EN is defined.
module vs0_dma_regs
  import vs0_dma_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 16,
  parameter int SLV_ADR_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SLV_ADR_W-1:0] wbs_adr,
  input  logic [31:0]          wbs_dat_w,
  input  logic [3:0]           wbs_sel,
  input  logic                 wbs_cyc,
  input  logic                 wbs_stb,
  input  logic                 wbs_we,
  output logic [31:0]          wbs_dat_r,
  output logic                 wbs_ack,
  input  logic [31:0]          irq_in,
  output logic                 irq_out,
  input  logic                 busy,
  input  logic [LEN_W-1:0]     remain,
  input  logic                 evt_done,
  input  logic                 evt_err,
  input  logic                 evt_aborted,
  output logic                 start,
  output logic                 abort,
  output logic [ADDR_W-1:0]    src,
  output logic [ADDR_W-1:0]    dst,
  output logic [LEN_W-1:0]     len
);

  logic        req;
  logic        wr;
  logic [2:0]  off;
  logic        ie;
  logic        done;
  logic        err;
  logic        aborted;
  logic [31:0] rdata;
  logic [31:0] irq_mask_rd;
  logic        irq_fwd;
  logic        unused;

  assign req   = wbs_cyc & wbs_stb;
  assign wr    = req & wbs_we;
  assign off   = wbs_adr[2:0];
  assign start = wr && (off == OFF_CTRL) && wbs_dat_w[CTRL_START] && !busy;
  assign abort = wr && (off == OFF_CTRL) && wbs_dat_w[CTRL_ABORT] && busy;
  assign unused = &{1'b0, wbs_sel, wbs_adr, wbs_dat_w, irq_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (wr) begin
      case (off)
        OFF_CTRL: ie  <= wbs_dat_w[CTRL_IE];
        OFF_SRC:  src <= wbs_dat_w[ADDR_W-1:0];
        OFF_DST:  dst <= wbs_dat_w[ADDR_W-1:0];
        OFF_LEN:  len <= wbs_dat_w[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Later assignments win: engine events override a simultaneous W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (wr && (off == OFF_STATUS)) begin
        if (wbs_dat_w[ST_DONE])    done    <= 1'b0;
        if (wbs_dat_w[ST_ERR])     err     <= 1'b0;
        if (wbs_dat_w[ST_ABORTED]) aborted <= 1'b0;
      end
      if (start) begin
        if (len != '0) begin
          done    <= 1'b0;
          err     <= 1'b0;
          aborted <= 1'b0;
        end else begin
          done <= 1'b1;
        end
      end
      if (evt_done)    done    <= 1'b1;
      if (evt_err)     err     <= 1'b1;
      if (evt_aborted) aborted <= 1'b1;
    end
  end

`ifdef VS0_DMA_IRQ_FWD_EN
  logic [31:0] irq_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_mask <= '0;
    else if (wr && (off == OFF_IRQ_MASK)) irq_mask <= wbs_dat_w;
  end

  assign irq_mask_rd = irq_mask;
  assign irq_fwd     = |(irq_in & irq_mask);
`else
  assign irq_mask_rd = '0;
  assign irq_fwd     = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata[CTRL_IE] = ie;
      OFF_STATUS: begin
        rdata[ST_BUSY]    = busy;
        rdata[ST_DONE]    = done;
        rdata[ST_ERR]     = err;
        rdata[ST_ABORTED] = aborted;
      end
      OFF_SRC:      rdata[ADDR_W-1:0] = src;
      OFF_DST:      rdata[ADDR_W-1:0] = dst;
      OFF_LEN:      rdata[LEN_W-1:0]  = len;
      OFF_IRQ_MASK: rdata = irq_mask_rd;
      OFF_REMAIN:   rdata[LEN_W-1:0]  = remain;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack   <= 1'b0;
      wbs_dat_r <= '0;
      irq_out   <= 1'b0;
    end else begin
      wbs_ack   <= req;
      wbs_dat_r <= req ? rdata : '0;
      irq_out   <= (ie & (done | err | aborted)) | irq_fwd;
    end
  end

endmodule

// File: rtl/vs0_dma.sv
// vs0_dma: register-programmed word copy engine; master FSM and working counters.
// Build option VS0_DMA_IRQ_FWD_EN adds IRQ_MASK and forwarding of irq_in to irq_out.
module vs0_dma
  import vs0_dma_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 16,
  parameter int SLV_ADR_W = 20
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  output logic [ADDR_W-1:0]    wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_stb_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_stall_i,
  output logic                 wbm_cyc_o,
  input  logic                 wbm_err_i,
  input  logic [SLV_ADR_W-1:0] wbs_adr,
  input  logic [31:0]          wbs_dat_w,
  output logic [31:0]          wbs_dat_r,
  input  logic [3:0]           wbs_sel,
  output logic                 wbs_stall,
  input  logic                 wbs_cyc,
  input  logic                 wbs_stb,
  output logic                 wbs_ack,
  input  logic                 wbs_we,
  output logic                 wbs_err,
  input  logic [31:0]          irq_in,
  output logic                 irq_out
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] src_cnt;
  logic [ADDR_W-1:0] dst_cnt;
  logic [LEN_W-1:0]  remain;
  logic [31:0]       data;
  logic              abort_pend;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              load;
  logic              evt_done;
  logic              evt_err;
  logic              evt_aborted;

  assign busy      = (state != IDLE);
  assign wbm_sel_o = 4'hF;
  assign wbm_dat_o = data;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;

  vs0_dma_regs #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .SLV_ADR_W (SLV_ADR_W)
  ) u_regs (
    .clk         (sys_clk),
    .rst_n       (rst_n),
    .wbs_adr     (wbs_adr),
    .wbs_dat_w   (wbs_dat_w),
    .wbs_sel     (wbs_sel),
    .wbs_cyc     (wbs_cyc),
    .wbs_stb     (wbs_stb),
    .wbs_we      (wbs_we),
    .wbs_dat_r   (wbs_dat_r),
    .wbs_ack     (wbs_ack),
    .irq_in      (irq_in),
    .irq_out     (irq_out),
    .busy        (busy),
    .remain      (remain),
    .evt_done    (evt_done),
    .evt_err     (evt_err),
    .evt_aborted (evt_aborted),
    .start       (start),
    .abort       (abort),
    .src         (src),
    .dst         (dst),
    .len         (len)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    evt_done    = 1'b0;
    evt_err     = 1'b0;
    evt_aborted = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_adr_o   = '0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          load       = 1'b1;
          next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = src_cnt;
        if (!wbm_stall_i) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        wbm_cyc_o = 1'b1;
        wbm_adr_o = src_cnt;
        if (wbm_err_i) begin
          evt_err    = 1'b1;
          next_state = IDLE;
        end else if (wbm_ack_i) begin
          next_state = WR_REQ;
        end
      end
      WR_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = dst_cnt;
        if (!wbm_stall_i) next_state = WR_WAIT;
      end
      WR_WAIT: begin
        wbm_cyc_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = dst_cnt;
        if (wbm_err_i) begin
          evt_err    = 1'b1;
          next_state = IDLE;
        end else if (wbm_ack_i) begin
          // An abort arriving with this ack still stops after the current word.
          if (remain == LEN_W'(1)) begin
            evt_done   = 1'b1;
            next_state = IDLE;
          end else if (abort_pend || abort) begin
            evt_aborted = 1'b1;
            next_state  = IDLE;
          end else begin
            next_state = RD_REQ;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt    <= '0;
      dst_cnt    <= '0;
      remain     <= '0;
      data       <= '0;
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= (next_state == IDLE) ? 1'b0 : (abort_pend | abort);
      if (load) begin
        src_cnt <= src;
        dst_cnt <= dst;
        remain  <= len;
      end
      if ((state == RD_WAIT) && wbm_ack_i && !wbm_err_i) data <= wbm_dat_i;
      if ((state == WR_WAIT) && wbm_ack_i && !wbm_err_i) begin
        src_cnt <= src_cnt + ADDR_W'(1);
        dst_cnt <= dst_cnt + ADDR_W'(1);
        remain  <= remain - LEN_W'(1);
      end
    end
  end

endmodule
